// File: rtl/spi_stream_rx_if.sv
// spi_stream_rx_if: serial input, request and word/status outputs of the SPI stream receiver
interface spi_stream_rx_if #(parameter int OUT_W = 8);
  logic bit_stb;
  logic MISO;
  logic start_req;
  logic chip_select;
  logic [OUT_W-1:0] word_data;
  logic word_valid;
  logic word_chan;
  logic frame_done;
  logic timeout_err;
  logic busy;
  modport master (
    input  bit_stb, MISO, start_req,
    output chip_select, word_data, word_valid, word_chan, frame_done, timeout_err, busy
  );
  modport slave (
    output bit_stb, MISO, start_req,
    input  chip_select, word_data, word_valid, word_chan, frame_done, timeout_err, busy
  );
endinterface

// File: rtl/spi_stream_rx.sv
// spi_stream_rx: SPI receive sequencer; settle, tolerant header hunt with timeout, video/audio payload deserialisation
module spi_stream_rx #(
  parameter int              HDR_W       = 8,
  parameter logic [HDR_W-1:0] VIDEO_HDR  = 8'hFF,
  parameter logic [HDR_W-1:0] AUDIO_HDR  = 8'hAA,
  parameter int              MATCH_MIN   = 6,
  parameter int              OUT_W       = 8,
  parameter int              VIDEO_LEN   = 4096,
  parameter int              AUDIO_LEN   = 256,
  parameter bit              AUDIO_EN    = 1'b1,
  parameter int              SETTLE_BITS = 16,
  parameter int              HUNT_MAX    = 1024
) (
  input logic CLK_40,
  input logic reset_n,
  spi_stream_rx_if.master io
);
  localparam int LEN_MAX = VIDEO_LEN > AUDIO_LEN ? VIDEO_LEN : AUDIO_LEN;
  localparam int BW = $clog2(LEN_MAX + 1);
  localparam int HW = $clog2(HUNT_MAX + 1);
  localparam int SW = $clog2(SETTLE_BITS + 1);
  localparam int WW = $clog2(OUT_W);
  typedef enum logic [2:0] {IDLE, SETTLE, HUNT_V, HUNT_A, RX_V, RX_A, DONE, ABORT} state_t;
  state_t state, state_n;
  logic [SW-1:0] settle_cnt;
  logic [HW-1:0] hunt_cnt;
  logic [BW-1:0] bit_cnt;
  logic [WW-1:0] wcnt;
  logic [HDR_W-2:0] hdr_sr;
  logic [OUT_W-2:0] word_sr;
  logic [HDR_W-1:0] nxt_hdr;
  logic [OUT_W-1:0] nxt_word;
  logic hunting, rx, hit, word_full, last, active_n;
  function automatic int ones(input logic [HDR_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < HDR_W; i++) n += {31'd0, v[i]};
    return n;
  endfunction
  always_comb begin
    state_n   = state;
    nxt_hdr   = {hdr_sr, io.MISO};
    nxt_word  = {word_sr, io.MISO};
    hunting   = state == HUNT_V || state == HUNT_A;
    rx        = state == RX_V || state == RX_A;
    hit       = io.bit_stb && hunt_cnt >= HW'(HDR_W - 1) &&
                ones(~(nxt_hdr ^ (state == HUNT_A ? AUDIO_HDR : VIDEO_HDR))) >= MATCH_MIN;
    word_full = io.bit_stb && rx && wcnt == WW'(OUT_W - 1);
    last      = io.bit_stb && bit_cnt == BW'((state == RX_A ? AUDIO_LEN : VIDEO_LEN) - 1);
    case (state)
      IDLE:    state_n = io.start_req ? SETTLE : IDLE;
      SETTLE:  state_n = io.bit_stb && settle_cnt == SW'(SETTLE_BITS - 1) ? HUNT_V : SETTLE;
      HUNT_V:  state_n = hit ? RX_V : io.bit_stb && hunt_cnt == HW'(HUNT_MAX - 1) ? ABORT : HUNT_V;
      HUNT_A:  state_n = hit ? RX_A : io.bit_stb && hunt_cnt == HW'(HUNT_MAX - 1) ? ABORT : HUNT_A;
      RX_V:    state_n = last ? (AUDIO_EN ? HUNT_A : DONE) : RX_V;
      RX_A:    state_n = last ? DONE : RX_A;
      default: state_n = IDLE;
    endcase
    active_n = state_n inside {SETTLE, HUNT_V, HUNT_A, RX_V, RX_A};
  end
  always_ff @(posedge CLK_40 or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // every state change clears the hunt and payload counters so each phase starts fresh
  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt     <= '0;
      hunt_cnt       <= '0;
      bit_cnt        <= '0;
      wcnt           <= '0;
      hdr_sr         <= '0;
      word_sr        <= '0;
      io.chip_select <= 1'b1;
      io.word_data   <= '0;
      io.word_valid  <= 1'b0;
      io.word_chan   <= 1'b0;
      io.frame_done  <= 1'b0;
      io.timeout_err <= 1'b0;
    end else begin
      settle_cnt     <= state == SETTLE ? settle_cnt + SW'(io.bit_stb) : '0;
      io.chip_select <= !active_n;
      io.frame_done  <= state_n == DONE;
      io.timeout_err <= state_n == ABORT;
      io.word_valid  <= word_full;
      if (word_full) begin
        io.word_data <= nxt_word;
        io.word_chan <= state == RX_A;
      end
      if (state_n != state) begin
        hdr_sr   <= '0;
        hunt_cnt <= '0;
        word_sr  <= '0;
        wcnt     <= '0;
        bit_cnt  <= '0;
      end else if (io.bit_stb && hunting) begin
        hdr_sr   <= nxt_hdr[HDR_W-2:0];
        hunt_cnt <= hunt_cnt + 1'b1;
      end else if (io.bit_stb && rx) begin
        word_sr <= nxt_word[OUT_W-2:0];
        wcnt    <= word_full ? '0 : wcnt + 1'b1;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
  assign io.busy = state != IDLE;
endmodule
